spi_slave: RTL and testbench

SPI responder (mode 0, MSB first) that lets an external SPI initiator exchange bytes with the core. The initiator is typically the board microcontroller or a second FPGA. All pin inputs are oversampled on the system clock, so no logic is clocked from SCLK. Received bytes are presented to the core as one-cycle strobes. Bytes to send are queued through a one-byte holding register. Idle MISO is 1, matching the all-ones filler the core's own SPI initiator sends while reading.

---
 rtl/spi_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, fully oversampled on clk.
// SCLK, CS and MOSI are synchronized and edge-detected in the clk domain;
// nothing is clocked from SCLK. Received bytes leave as one-cycle strobes,
// outgoing bytes are queued through a one-byte holding register, and MISO
// idles high so an empty holding register sends 8'hFF filler.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_di,
    output logic       spi_do,
    output logic       spi_do_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_empty,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_start,
    output logic       frame_end
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer plus one history flop each
    // ------------------------------------------------------------------
    logic sclk_meta_q, sclk_meta_d;
    logic sclk_sync_q, sclk_sync_d;
    logic sclk_hist_q, sclk_hist_d;
    logic cs_meta_q,   cs_meta_d;
    logic cs_sync_q,   cs_sync_d;
    logic cs_hist_q,   cs_hist_d;
    logic di_meta_q,   di_meta_d;
    logic di_sync_q,   di_sync_d;
    logic di_hist_q,   di_hist_d;

    // ------------------------------------------------------------------
    // Frame state, shifters and holding register
    // ------------------------------------------------------------------
    state_t     state_q,       state_d;
    logic [2:0] bit_cnt_q,     bit_cnt_d;
    logic       byte_done_q,   byte_done_d;
    logic [7:0] shift_in_q,    shift_in_d;
    logic [7:0] shift_out_q,   shift_out_d;
    logic [7:0] hold_q,        hold_d;
    logic       hold_full_q,   hold_full_d;

    // Registered outputs
    logic [7:0] rx_data_q,     rx_data_d;
    logic       rx_valid_q,    rx_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q,   frame_end_d;
    logic       spi_do_q,      spi_do_d;
    logic       spi_do_oe_q,   spi_do_oe_d;

    // Edge strobes derived from the synchronized copies only
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;
    logic       cs_edge;
    logic [7:0] next_byte;
    logic       load_byte;

    assign sclk_rise = sclk_sync_q & ~sclk_hist_q;
    assign sclk_fall = ~sclk_sync_q & sclk_hist_q;
    assign cs_fall   = ~cs_sync_q & cs_hist_q;
    assign cs_rise   = cs_sync_q & ~cs_hist_q;
    assign cs_edge   = cs_fall | cs_rise;

    // Byte presented to the shifter on a load: queued byte, else filler
    assign next_byte = hold_full_q ? hold_q : 8'hFF;

    // Synchronizer chain next-state: each stage copies the one before it
    always_comb begin
        sclk_meta_d = spi_clk;
        sclk_sync_d = sclk_meta_q;
        sclk_hist_d = sclk_sync_q;
        cs_meta_d   = spi_cs_n;
        cs_sync_d   = cs_meta_q;
        cs_hist_d   = cs_sync_q;
        di_meta_d   = spi_di;
        di_sync_d   = di_meta_q;
        di_hist_d   = di_sync_q;
    end

    // Frame FSM, shifters, holding register and output next-state
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_done_d   = byte_done_q;
        shift_in_d    = shift_in_q;
        shift_out_d   = shift_out_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        spi_do_d      = spi_do_q;
        spi_do_oe_d   = spi_do_oe_q;
        load_byte     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d   = 3'd0;
                byte_done_d = 1'b0;
                spi_do_d    = 1'b1;
                spi_do_oe_d = 1'b0;
                if (cs_fall) begin
                    state_d       = ST_ACTIVE;
                    frame_start_d = 1'b1;
                    load_byte     = 1'b1;
                    shift_out_d   = next_byte;
                    spi_do_d      = next_byte[7];
                    spi_do_oe_d   = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (cs_rise) begin
                    // Partial byte is dropped; the holding register is kept
                    state_d     = ST_IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                    spi_do_d    = 1'b1;
                    spi_do_oe_d = 1'b0;
                end else if (!cs_edge) begin
                    if (sclk_rise) begin
                        // MOSI is taken from the stage aligned with the pre-edge SCLK level
                        shift_in_d = {shift_in_q[6:0], di_hist_q};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = {shift_in_q[6:0], di_hist_q};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            load_byte   = 1'b1;
                            shift_out_d = next_byte;
                            spi_do_d    = next_byte[7];
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                            spi_do_d    = shift_out_q[6];
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write wins over a same-cycle load: the load above already took the old contents
        if (tx_write) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (load_byte) begin
            hold_full_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q   <= 1'b0;
            sclk_sync_q   <= 1'b0;
            sclk_hist_q   <= 1'b0;
            // NOTE: CS stages reset to "selected" so a frame still active at reset release shows no falling edge; the next frame must start from a real deassert/assert.
            cs_meta_q     <= 1'b0;
            cs_sync_q     <= 1'b0;
            cs_hist_q     <= 1'b0;
            di_meta_q     <= 1'b0;
            di_sync_q     <= 1'b0;
            di_hist_q     <= 1'b0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            byte_done_q   <= 1'b0;
            shift_in_q    <= 8'h00;
            shift_out_q   <= 8'hFF;
            hold_q        <= 8'h00;
            hold_full_q   <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            spi_do_q      <= 1'b1;
            spi_do_oe_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, exactly like hardware.
            sclk_meta_q   <= sclk_meta_d;
            sclk_sync_q   <= sclk_sync_d;
            sclk_hist_q   <= sclk_hist_d;
            cs_meta_q     <= cs_meta_d;
            cs_sync_q     <= cs_sync_d;
            cs_hist_q     <= cs_hist_d;
            di_meta_q     <= di_meta_d;
            di_sync_q     <= di_sync_d;
            di_hist_q     <= di_hist_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_done_q   <= byte_done_d;
            shift_in_q    <= shift_in_d;
            shift_out_q   <= shift_out_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            spi_do_q      <= spi_do_d;
            spi_do_oe_q   <= spi_do_oe_d;
        end
    end

    assign spi_do      = spi_do_q;
    assign spi_do_oe   = spi_do_oe_q;
    assign tx_empty    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed, table-driven bench for spi_slave.
// The bench plays the SPI initiator at SCLK = clk/16, counts strobes with a
// monitor, and compares MISO/MOSI bytes against hand-computed values.
module tb_spi_slave;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_clk  = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_di   = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_write = 1'b0;
    logic       spi_do;
    logic       spi_do_oe;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_start;
    logic       frame_end;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_di      (spi_di),
        .spi_do      (spi_do),
        .spi_do_oe   (spi_do_oe),
        .tx_data     (tx_data),
        .tx_write    (tx_write),
        .tx_empty    (tx_empty),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitor: counts pulses, logs received bytes, flags pulses wider than 1 clk
    int         rx_cnt   = 0;
    int         fs_cnt   = 0;
    int         fe_cnt   = 0;
    int         wide_cnt = 0;
    logic [7:0] rx_log [0:63];
    logic       rx_p = 1'b0;
    logic       fs_p = 1'b0;
    logic       fe_p = 1'b0;

    always @(posedge clk) begin
        if (rx_valid === 1'b1) begin
            if (rx_cnt < 64) rx_log[rx_cnt] = rx_data;
            rx_cnt++;
        end
        if (frame_start === 1'b1) fs_cnt++;
        if (frame_end === 1'b1) fe_cnt++;
        if ((rx_valid === 1'b1 && rx_p) || (frame_start === 1'b1 && fs_p) ||
            (frame_end === 1'b1 && fe_p)) wide_cnt++;
        rx_p = (rx_valid === 1'b1);
        fs_p = (frame_start === 1'b1);
        fe_p = (frame_end === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One SCLK period: MOSI set with the falling edge, MISO read just before the rising edge
    task automatic spi_bit(input logic b, output logic o);
        spi_di = b;
        repeat (8) @(negedge clk);
        o = spi_do;
        spi_clk = 1'b1;
        repeat (8) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mosi[i], o);
            miso[i] = o;
        end
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        @(negedge clk);
        tx_write = 1'b0;
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    typedef struct {
        bit         use_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] m0, m1, m2;
        logic       o;
        int         s_rx, s_fs, s_fe;
        int         bad_do, bad_oe, bad_te, bad_st;
        int         k;
        bit         found;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 8'h96, 8'hFF, 8'h96};
        vecs[4] = '{1'b1, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
        vecs[5] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check("rst_spi_do",      32'(spi_do),      1);
        check("rst_spi_do_oe",   32'(spi_do_oe),   0);
        check("rst_tx_empty",    32'(tx_empty),    1);
        check("rst_rx_data",     32'(rx_data),     0);
        check("rst_rx_valid",    32'(rx_valid),    0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_frame_end",   32'(frame_end),   0);
        rst_n = 1'b1;

        // Idle for 100 clk: outputs static, no strobes
        bad_do = 0; bad_oe = 0; bad_te = 0; bad_st = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (spi_do !== 1'b1) bad_do++;
            if (spi_do_oe !== 1'b0) bad_oe++;
            if (tx_empty !== 1'b1) bad_te++;
            if (rx_valid !== 1'b0 || frame_start !== 1'b0 || frame_end !== 1'b0) bad_st++;
        end
        check("idle_spi_do_cycles",   bad_do, 0);
        check("idle_oe_cycles",       bad_oe, 0);
        check("idle_tx_empty_cycles", bad_te, 0);
        check("idle_strobe_cycles",   bad_st, 0);

        // Table: one-byte frames
        for (int i = 0; i < 6; i++) begin
            s_rx = rx_cnt; s_fs = fs_cnt; s_fe = fe_cnt;
            if (vecs[i].use_tx) tx_push(vecs[i].tx);
            spi_cs_n = 1'b0;
            repeat (8) @(negedge clk);
            check($sformatf("v%0d_tx_empty_after_cs", i), 32'(tx_empty), 1);
            check($sformatf("v%0d_oe_in_frame", i), 32'(spi_do_oe), 1);
            spi_byte(vecs[i].mosi, m0);
            cs_high();
            check($sformatf("v%0d_miso", i), 32'(m0), 32'(vecs[i].exp_miso));
            check($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d_rx_valid_pulses", i), rx_cnt - s_rx, 1);
            check($sformatf("v%0d_frame_start_pulses", i), fs_cnt - s_fs, 1);
            check($sformatf("v%0d_frame_end_pulses", i), fe_cnt - s_fe, 1);
            check($sformatf("v%0d_oe_after", i), 32'(spi_do_oe), 0);
            check($sformatf("v%0d_spi_do_after", i), 32'(spi_do), 1);
        end

        // Three-byte frame: 81 queued, 7E written during byte 1, then filler
        s_rx = rx_cnt; s_fs = fs_cnt; s_fe = fe_cnt;
        tx_push(8'h81);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        tx_push(8'h7E);
        check("b3_tx_empty_after_write", 32'(tx_empty), 0);
        spi_byte(8'h01, m0);
        spi_byte(8'h02, m1);
        spi_byte(8'h03, m2);
        cs_high();
        check("b3_miso0", 32'(m0), 'h81);
        check("b3_miso1", 32'(m1), 'h7E);
        check("b3_miso2", 32'(m2), 'hFF);
        check("b3_rx_pulses", rx_cnt - s_rx, 3);
        check("b3_rx0", 32'(rx_log[s_rx]),     'h01);
        check("b3_rx1", 32'(rx_log[s_rx + 1]), 'h02);
        check("b3_rx2", 32'(rx_log[s_rx + 2]), 'h03);
        check("b3_frame_start_pulses", fs_cnt - s_fs, 1);
        check("b3_frame_end_pulses", fe_cnt - s_fe, 1);
        check("b3_tx_empty_end", 32'(tx_empty), 1);

        // Partial frame: 5 SCLK cycles, then CS deasserted
        s_rx = rx_cnt; s_fe = fe_cnt;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bit(1'b1, o);
        spi_bit(1'b0, o);
        spi_bit(1'b1, o);
        spi_bit(1'b1, o);
        spi_bit(1'b0, o);
        cs_high();
        check("part_rx_pulses", rx_cnt - s_rx, 0);
        check("part_frame_end_pulses", fe_cnt - s_fe, 1);
        check("part_rx_data_held", 32'(rx_data), 'h03);
        s_rx = rx_cnt;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_byte(8'hC3, m0);
        cs_high();
        check("after_part_rx_data", 32'(rx_data), 'hC3);
        check("after_part_rx_pulses", rx_cnt - s_rx, 1);
        check("after_part_miso", 32'(m0), 'hFF);

        // Measure CS-fall to frame_start distance to hit the load cycle exactly
        check("pre_same_tx_empty", 32'(tx_empty), 1);
        spi_cs_n = 1'b0;
        k = 3; found = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                k = j;
                found = 1'b1;
                break;
            end
        end
        check("cs_fall_detected", 32'(found), 1);
        check("cs_fall_latency_in_range", 32'(k >= 2 && k <= 5), 1);
        cs_high();

        // tx_write in the same cycle as the CS-fall load with an empty register
        s_rx = rx_cnt;
        spi_cs_n = 1'b0;
        repeat (k - 1) @(negedge clk);
        tx_data  = 8'h6B;
        tx_write = 1'b1;
        @(negedge clk);
        tx_write = 1'b0;
        check("same_frame_start_aligned", 32'(frame_start), 1);
        check("same_tx_empty_after_load", 32'(tx_empty), 0);
        repeat (6) @(negedge clk);
        spi_byte(8'h11, m0);
        check("same_tx_empty_in_byte0", 32'(tx_empty), 0);
        spi_byte(8'h22, m1);
        cs_high();
        check("same_miso0", 32'(m0), 'hFF);
        check("same_miso1", 32'(m1), 'h6B);
        check("same_rx_pulses", rx_cnt - s_rx, 2);
        check("same_rx0", 32'(rx_log[s_rx]),     'h11);
        check("same_rx1", 32'(rx_log[s_rx + 1]), 'h22);
        check("same_tx_empty_end", 32'(tx_empty), 1);

        // Reset pulsed mid-byte with a byte queued and CS kept low afterwards
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        tx_push(8'h44);
        spi_bit(1'b1, o);
        spi_bit(1'b0, o);
        spi_bit(1'b1, o);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_spi_do",      32'(spi_do),      1);
        check("mid_rst_spi_do_oe",   32'(spi_do_oe),   0);
        check("mid_rst_tx_empty",    32'(tx_empty),    1);
        check("mid_rst_rx_data",     32'(rx_data),     0);
        check("mid_rst_rx_valid",    32'(rx_valid),    0);
        check("mid_rst_frame_start", 32'(frame_start), 0);
        check("mid_rst_frame_end",   32'(frame_end),   0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s_rx = rx_cnt; s_fs = fs_cnt;
        bad_do = 0; bad_oe = 0;
        for (int b = 0; b < 13; b++) begin
            spi_bit(b[0], o);
            if (o !== 1'b1) bad_do++;
            if (spi_do_oe !== 1'b0) bad_oe++;
        end
        check("post_rst_ignored_rx", rx_cnt - s_rx, 0);
        check("post_rst_ignored_fs", fs_cnt - s_fs, 0);
        check("post_rst_ignored_do", bad_do, 0);
        check("post_rst_ignored_oe", bad_oe, 0);
        cs_high();
        s_rx = rx_cnt; s_fs = fs_cnt;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_byte(8'h5A, m0);
        cs_high();
        check("post_rst_rx_data", 32'(rx_data), 'h5A);
        check("post_rst_rx_pulses", rx_cnt - s_rx, 1);
        check("post_rst_fs_pulses", fs_cnt - s_fs, 1);
        check("post_rst_miso", 32'(m0), 'hFF);

        check("strobe_width_violations", wide_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
